// File: rtl/fdb_pkg.sv
// Shared defaults and entry type for the fetch/decode elastic buffer.
package fdb_pkg;
  localparam int DEPTH   = 4;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fdb_entry_t;
endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle for fetch_decode_buffer.
interface fetch_decode_buffer_if #(
  parameter int DEPTH   = fdb_pkg::DEPTH,
  parameter int PC_W    = fdb_pkg::PC_W,
  parameter int INSTR_W = fdb_pkg::INSTR_W
);
  logic                     valid_F;
  logic [PC_W-1:0]          pc_F;
  logic [INSTR_W-1:0]       instr_F;
  logic                     ready_F;
  logic                     flush;
  logic                     valid_D;
  logic [PC_W-1:0]          pc_D;
  logic [INSTR_W-1:0]       instr_D;
  logic                     ready_D;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  valid_F, pc_F, instr_F, flush, ready_D,
    output ready_F, valid_D, pc_D, instr_D, count
  );

  modport master (
    output valid_F, pc_F, instr_F, flush, ready_D,
    input  ready_F, valid_D, pc_D, instr_D, count
  );
endinterface

// File: rtl/fdb_storage.sv
// Entry array: synchronous write, combinational read, no reset on contents.
module fdb_storage
  import fdb_pkg::*;
#(
  parameter int DEPTH = fdb_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fdb_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output fdb_entry_t    rdata
);
  fdb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic FIFO between fetch and decode; a taken branch (flush) empties it.
module fetch_decode_buffer #(
  parameter int DEPTH   = fdb_pkg::DEPTH,
  parameter int PC_W    = fdb_pkg::PC_W,
  parameter int INSTR_W = fdb_pkg::INSTR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_buffer_if.slave bus
);
  import fdb_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               full, empty, enq, deq;
  fdb_entry_t         wr_entry, rd_entry;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // No full pass-through: a full buffer refuses fetch even while decode drains.
  assign enq   = bus.valid_F && !full && !bus.flush;
  assign deq   = !empty && bus.ready_D && !bus.flush;

  assign wr_entry.pc    = bus.pc_F;
  assign wr_entry.instr = bus.instr_F;

  fdb_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale array contents are masked so decode only ever sees zeros when empty.
  assign head_pc    = empty ? '0 : rd_entry.pc;
  assign head_instr = empty ? '0 : rd_entry.instr;

  assign bus.ready_F = !full;
  assign bus.valid_D = !empty;
  assign bus.pc_D    = head_pc;
  assign bus.instr_D = head_instr;
  assign bus.count   = count_q;
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer with hand-computed expectations.
module tb_fetch_decode_buffer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  fetch_decode_buffer_if bus ();

  fetch_decode_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [63:0] pc, input logic [31:0] instr);
    bus.valid_F = v;
    bus.pc_F    = pc;
    bus.instr_F = instr;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.ready_D = 1'b0;
    drive_f(1'b1, 64'd4, 32'h1234_5678);

    // reset held with fetch presenting a pair
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_valid_D", 64'(bus.valid_D), 64'd0);
      chk("rst_ready_F", 64'(bus.ready_F), 64'd1);
      chk("rst_count",   64'(bus.count),   64'd0);
      chk("rst_pc_D",    bus.pc_D,         64'd0);
    end
    drive_f(1'b0, 64'd0, 32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_count", 64'(bus.count), 64'd0);

    // single pass
    drive_f(1'b1, 64'h10, 32'h8B02_0020);
    step();
    drive_f(1'b0, 64'd0, 32'd0);
    chk("single_valid_D", 64'(bus.valid_D), 64'd1);
    chk("single_pc_D",    bus.pc_D,         64'h10);
    chk("single_instr_D", 64'(bus.instr_D), 64'h8B02_0020);
    chk("single_count",   64'(bus.count),   64'd1);
    bus.ready_D = 1'b1;
    step();
    bus.ready_D = 1'b0;
    chk("single_drain_valid", 64'(bus.valid_D), 64'd0);
    chk("single_drain_count", 64'(bus.count),   64'd0);
    chk("single_drain_pc",    bus.pc_D,         64'd0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      drive_f(1'b1, 64'(4 * i), 32'(32'h100 + i));
      step();
      chk("fill_count", 64'(bus.count), 64'(i + 1));
    end
    chk("full_ready_F", 64'(bus.ready_F), 64'd0);
    drive_f(1'b1, 64'd16, 32'h0000_0116);
    step();
    chk("full_drop_count", 64'(bus.count), 64'd4);
    chk("full_head_pc",    bus.pc_D,       64'd0);
    // dequeue while fetch still presents 16: it must not slip in
    bus.ready_D = 1'b1;
    step();
    drive_f(1'b0, 64'd0, 32'd0);
    chk("full_deq_count", 64'(bus.count),   64'd3);
    chk("full_ready_ret", 64'(bus.ready_F), 64'd1);
    chk("drain_pc_4",     bus.pc_D,         64'd4);
    chk("drain_instr_4",  64'(bus.instr_D), 64'h101);
    step();
    chk("drain_pc_8",     bus.pc_D,         64'd8);
    step();
    chk("drain_pc_12",    bus.pc_D,         64'd12);
    step();
    bus.ready_D = 1'b0;
    chk("drain_empty_valid", 64'(bus.valid_D), 64'd0);
    chk("drain_empty_count", 64'(bus.count),   64'd0);

    // simultaneous enqueue/dequeue at count 2, wrapping both pointers
    drive_f(1'b1, 64'd100, 32'h200);
    step();
    drive_f(1'b1, 64'd104, 32'h204);
    step();
    chk("sim_pre_count", 64'(bus.count), 64'd2);
    bus.ready_D = 1'b1;
    drive_f(1'b1, 64'd20, 32'h300);
    chk("sim_head_100", bus.pc_D, 64'd100);
    step();
    chk("sim_count_a", 64'(bus.count), 64'd2);
    drive_f(1'b1, 64'd24, 32'h304);
    chk("sim_head_104", bus.pc_D, 64'd104);
    step();
    chk("sim_count_b", 64'(bus.count), 64'd2);
    drive_f(1'b1, 64'd28, 32'h308);
    chk("sim_head_20", bus.pc_D, 64'd20);
    step();
    chk("sim_count_c", 64'(bus.count), 64'd2);
    drive_f(1'b0, 64'd0, 32'd0);
    chk("sim_head_24",  bus.pc_D,         64'd24);
    chk("sim_instr_24", 64'(bus.instr_D), 64'h304);
    step();
    chk("sim_head_28",  bus.pc_D,         64'd28);
    step();
    bus.ready_D = 1'b0;
    chk("sim_end_count", 64'(bus.count), 64'd0);

    // flush with 3 entries, beating a same-cycle enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drive_f(1'b1, 64'(200 + 4 * i), 32'(32'h400 + i));
      step();
    end
    chk("flush_pre_count", 64'(bus.count), 64'd3);
    bus.flush   = 1'b1;
    bus.ready_D = 1'b1;
    drive_f(1'b1, 64'd40, 32'h0000_0440);
    step();
    bus.flush   = 1'b0;
    bus.ready_D = 1'b0;
    chk("flush_count",   64'(bus.count),   64'd0);
    chk("flush_valid_D", 64'(bus.valid_D), 64'd0);
    chk("flush_pc_D",    bus.pc_D,         64'd0);
    chk("flush_ready_F", 64'(bus.ready_F), 64'd1);
    drive_f(1'b1, 64'd20, 32'h0000_0520);
    step();
    drive_f(1'b0, 64'd0, 32'd0);
    chk("target_valid_D", 64'(bus.valid_D), 64'd1);
    chk("target_pc_D",    bus.pc_D,         64'd20);
    chk("target_instr_D", 64'(bus.instr_D), 64'h520);
    chk("target_count",   64'(bus.count),   64'd1);

    // async reset between edges with 3 entries held
    drive_f(1'b1, 64'd24, 32'h524);
    step();
    drive_f(1'b1, 64'd28, 32'h528);
    step();
    drive_f(1'b0, 64'd0, 32'd0);
    chk("arst_pre_count", 64'(bus.count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid_D", 64'(bus.valid_D), 64'd0);
    chk("arst_count",   64'(bus.count),   64'd0);
    chk("arst_pc_D",    bus.pc_D,         64'd0);
    chk("arst_ready_F", 64'(bus.ready_F), 64'd1);
    reset = 1'b1;
    step();
    chk("arst_after_count", 64'(bus.count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Elastic buffer between the fetch stage and the decode stage of the 64-bit pipelined core. It captures each fetched {PC, instruction} pair from fetch and presents it in order to decode. It decouples a decode stall from fetch through a small FIFO. A taken branch (PCSrc) flushes every buffered entry.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_F  in  1  fetch presents a pair this cycle.
- pc_F  in  PC_W  PC of the fetched instruction (imem_addr_F).
- instr_F  in  INSTR_W  instruction read from imem at pc_F.
- ready_F  out  1  buffer accepts a pair; equals !full.
- flush  in  1  taken branch (PCSrc_F); discards all entries.
- valid_D  out  1  head entry valid; equals !empty.
- pc_D  out  PC_W  PC of the head entry; 0 when empty.
- instr_D  out  INSTR_W  instruction of the head entry; 0 when empty.
- ready_D  in  1  decode consumes the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage: circular array of DEPTH entries, with read pointer rd_ptr, write pointer wr_ptr and occupancy count.
- Enqueue when valid_F && ready_F && !flush:
  - write {pc_F, instr_F} at wr_ptr;
  - wr_ptr = (wr_ptr+1) mod DEPTH.
- Dequeue when valid_D && ready_D && !flush: rd_ptr = (rd_ptr+1) mod DEPTH.
- count update:
  - +1 on enqueue only;
  - −1 on dequeue only;
  - unchanged when both occur or neither occurs.
- Full (count == DEPTH):
  - ready_F = 0.
  - valid_F is ignored, even if a dequeue happens in the same cycle. There is no full-pass-through.
  - ready_F returns to 1 in the cycle after a dequeue.
- Empty (count == 0):
  - valid_D = 0; pc_D and instr_D are forced to 0.
  - No bypass: an entry enqueued in cycle N is visible to decode in cycle N+1.
- ready_D while valid_D = 0 has no effect.
- Flush:
  - rd_ptr, wr_ptr and count are cleared to 0 at the next edge.
  - Flush has priority over a same-cycle enqueue and dequeue; both are dropped.
  - Array contents are left stale; they are unreachable once count = 0.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally at $clog2(DEPTH) bits.
- Reset:
  - Asynchronous, takes effect immediately when reset falls: pointers = 0, count = 0, valid_D = 0, pc_D = 0, instr_D = 0, ready_F = 1.
  - Reset asserted mid-operation drops every entry.
  - Deassertion is synchronous to clk through the usual reset synchroniser upstream; the first enqueue can occur on the first edge with reset = 1.

## Timing

- Enqueue-to-valid_D latency: 1 cycle when the buffer is empty.
- ready_F, valid_D, pc_D, instr_D and count are functions of registered state only. There is no combinational path from valid_F, ready_D or flush to any output.
- Sustained throughput: 1 pair per cycle when decode holds ready_D = 1.
- Flush-to-empty: valid_D = 0 in the cycle after flush is sampled high. A pair presented by fetch in that following cycle is accepted normally.

## Structure

- Shared package fdb_pkg:
  - DEPTH, PC_W, INSTR_W defaults;
  - typedef fdb_entry_t = struct {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;}.
- One natural sub-module, fdb_storage:
  - DEPTH × fdb_entry_t register array;
  - synchronous write port, combinational read port;
  - no reset on the array.
- Pointer, count and handshake logic live in fetch_decode_buffer.

## Test plan

- Reset: hold reset = 0 for 5 cycles, with valid_F = 1 and pc_F = 4 during reset → valid_D = 0, ready_F = 1, count = 0, pc_D = 0 throughout.
- Single pass: enqueue pc_F = 0x10, instr_F = 0x8B020020 with ready_D = 0 → next cycle valid_D = 1, pc_D = 0x10, instr_D = 0x8B020020, count = 1. Then ready_D = 1 for one cycle → valid_D = 0, count = 0.
- Fill/full: ready_D = 0, enqueue PCs 0, 4, 8, 12 → count = 4, ready_F = 0. Present PC 16 → it is dropped. Then drain with ready_D = 1 → decode sees 0, 4, 8, 12 in order, and never 16.
- Simultaneous enqueue/dequeue at count = 2:
  - enqueue 20 while dequeuing the head for 3 cycles → count stays 2;
  - order is preserved across pointer wrap-around (rd_ptr/wr_ptr pass 3→0).
- Flush: with 3 entries, assert flush together with valid_F = 1 (pc 40) and ready_D = 1 → next cycle count = 0, valid_D = 0, and pc 40 is never seen. Then enqueue pc 20 (the branch target) → valid_D = 1, pc_D = 20.
- Async reset mid-stream: drop reset between clock edges with count = 3 → valid_D = 0 and count = 0 immediately, before the next edge.
